// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Access size in bytes; 0 marks an undefined width code.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            F3_W:        return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

    // Stores only have signless widths.
    function automatic logic f3_legal(input logic write, input logic [2:0] funct3);
        if (write)
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        return size_of(funct3) != 3'd0;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: merges store bytes into memory words and extracts/extends load data.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic [2:0]  funct3,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    input  logic [31:0] wdata,
    output logic [31:0] wr_lo,
    output logic [31:0] wr_hi,
    output logic [31:0] load_data
);

    logic [3:0]  size_mask;
    logic [7:0]  lane_mask;
    logic [63:0] wshift;
    logic [31:0] raw;

    always_comb begin
        case (size)
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            3'd4:    size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
        // Lanes 0..3 belong to the low word, 4..7 to the next word up.
        lane_mask = 8'(size_mask) << off;
        wshift    = 64'(wdata) << {off, 3'b000};
        raw       = 32'({hi_word, lo_word} >> {off, 3'b000});

        wr_lo = lo_word;
        wr_hi = hi_word;
        for (int l = 0; l < 4; l++) begin
            if (lane_mask[l])
                wr_lo[8*l +: 8] = wshift[8*l +: 8];
            if (lane_mask[l+4])
                wr_hi[8*l +: 8] = wshift[32+8*l +: 8];
        end

        case (funct3)
            F3_B:    load_data = {{24{raw[7]}}, raw[7:0]};
            F3_H:    load_data = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   load_data = {24'd0, raw[7:0]};
            F3_HU:   load_data = {16'd0, raw[15:0]};
            default: load_data = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: splits requests into aligned word reads/writes
// with read-modify-write for partial stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_data_i
);

    state_t      state;
    logic        write_q;
    logic [2:0]  f3_q;
    logic [31:0] base_q;
    logic [1:0]  off_q;
    logic [2:0]  size_q;
    logic        cross_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;

    logic [2:0]  req_size;
    logic [32:0] req_last;
    logic        req_err;
    logic        req_cross;
    logic [31:0] req_base;
    logic [31:0] lo_word;
    logic [31:0] wr_lo;
    logic [31:0] wr_hi;
    logic [31:0] load_data;

    // Request decode, evaluated against the live inputs in IDLE.
    always_comb begin
        req_size  = size_of(req_funct3_i);
        req_last  = {1'b0, req_addr_i} + 33'(req_size) - 33'd1;
        req_err   = !f3_legal(req_write_i, req_funct3_i) || (req_last >= 33'(MEM_BYTES));
        req_cross = (4'(req_addr_i[1:0]) + 4'(req_size)) > 4'd4;
        req_base  = {req_addr_i[31:2], 2'b00};
        lo_word   = (state == RD_LO) ? mem_data_i : lo_q;
    end

    lsu_lane_align u_align (
        .off       (off_q),
        .size      (size_q),
        .funct3    (f3_q),
        .lo_word   (lo_word),
        .hi_word   (mem_data_i),
        .wdata     (wdata_q),
        .wr_lo     (wr_lo),
        .wr_hi     (wr_hi),
        .load_data (load_data)
    );

    // Outputs are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            mem_write_o <= 1'b0;
            mem_read_o  <= 1'b0;
            write_q     <= 1'b0;
            f3_q        <= '0;
            base_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            cross_q     <= 1'b0;
            wdata_q     <= '0;
            lo_q        <= '0;
        end else begin
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            mem_write_o <= 1'b0;
            mem_read_o  <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        write_q     <= req_write_i;
                        f3_q        <= req_funct3_i;
                        base_q      <= req_base;
                        off_q       <= req_addr_i[1:0];
                        size_q      <= req_size;
                        cross_q     <= req_cross;
                        wdata_q     <= req_wdata_i;
                        if (req_err) begin
                            state       <= DONE;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                        end else if (req_write_i && req_funct3_i == F3_W && req_addr_i[1:0] == 2'b00) begin
                            state       <= WR_LO;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= req_base;
                            mem_data_o  <= req_wdata_i;
                        end else begin
                            state      <= RD_LO;
                            mem_read_o <= 1'b1;
                            mem_addr_o <= req_base;
                        end
                    end
                end
                RD_LO: begin
                    lo_q <= mem_data_i;
                    if (write_q) begin
                        state       <= WR_LO;
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= base_q;
                        mem_data_o  <= wr_lo;
                    end else if (cross_q) begin
                        state      <= RD_HI;
                        mem_read_o <= 1'b1;
                        mem_addr_o <= base_q + 32'd4;
                    end else begin
                        state       <= DONE;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= load_data;
                    end
                end
                WR_LO: begin
                    if (cross_q) begin
                        state      <= RD_HI;
                        mem_read_o <= 1'b1;
                        mem_addr_o <= base_q + 32'd4;
                    end else begin
                        state       <= DONE;
                        rsp_valid_o <= 1'b1;
                    end
                end
                RD_HI: begin
                    if (write_q) begin
                        state       <= WR_HI;
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= base_q + 32'd4;
                        mem_data_o  <= wr_hi;
                    end else begin
                        state       <= DONE;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= load_data;
                    end
                end
                WR_HI: begin
                    state       <= DONE;
                    rsp_valid_o <= 1'b1;
                end
                DONE: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected memory strobes and responses are queued
// at issue time and checked by an independent negedge monitor.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_write_o;
    logic        mem_read_o;
    logic [31:0] mem_data_i;

    load_store_unit #(.MEM_BYTES(120)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_write_o  (mem_write_o),
        .mem_read_o   (mem_read_o),
        .mem_data_i   (mem_data_i)
    );

    always #5 clk = ~clk;

    // Word-organised memory model: combinational read, write at posedge.
    logic [31:0] mem_w [30];
    always_comb begin
        mem_data_i = '0;
        if (mem_read_o && mem_addr_o[31:2] < 30'd30)
            mem_data_i = mem_w[mem_addr_o[6:2]];
    end
    always @(posedge clk)
        if (mem_write_o && mem_addr_o[31:2] < 30'd30)
            mem_w[mem_addr_o[6:2]] <= mem_data_o;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int K_RD = 0;
    localparam int K_WR = 1;
    localparam int K_RSP = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          rel;
    } exp_t;

    exp_t q[$];
    int   acc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ex(input int kind, input logic [31:0] addr, input logic [31:0] data,
                      input logic err, input int rel);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.err = err; e.rel = rel;
        q.push_back(e);
    endtask

    // Monitor: every strobe or response must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (mem_read_o === 1'b1 && mem_write_o === 1'b1)
            check("rd_wr_exclusive", 32'd1, 32'd0);
        if (mem_read_o === 1'b1 || mem_write_o === 1'b1 || rsp_valid_o === 1'b1) begin
            kind = rsp_valid_o ? K_RSP : (mem_write_o ? K_WR : K_RD);
            if (q.size() == 0) begin
                check("unexpected_event_kind", 32'(kind), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("event_kind", 32'(kind), 32'(e.kind));
                check("event_cycle", 32'(cyc - acc), 32'(e.rel));
                if (e.kind == K_RSP) begin
                    check("rsp_rdata", rsp_rdata_o, e.data);
                    check("rsp_err", 32'(rsp_err_o), 32'(e.err));
                end else begin
                    check("mem_addr", mem_addr_o, e.addr);
                    if (e.kind == K_WR)
                        check("mem_wdata", mem_data_o, e.data);
                end
            end
        end else if (mem_addr_o !== 32'd0 || mem_data_o !== 32'd0) begin
            check("idle_mem_bus", mem_addr_o | mem_data_o, 32'd0);
        end
    end

    task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        @(negedge clk);
        check("ready_before_issue", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_write_i = w; req_funct3_i = f3;
        req_addr_i = a; req_wdata_i = wd;
        acc = cyc;
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("timeout_pending", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        drive(w, f3, a, wd);
        wait_empty();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
        check({tag, "_strobes"}, 32'({mem_read_o, mem_write_o}), 32'd0);
        check({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        check({tag, "_mem_data"}, mem_data_o, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 30; i++) mem_w[i] = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        check_idle_outputs("reset");

        // Aligned and sub-word loads.
        mem_w[0] = 32'h8433_2211;
        ex(K_RD, 32'd0, 0, 0, 1); ex(K_RSP, 0, 32'h8433_2211, 0, 2);
        issue(1'b0, 3'b010, 32'd0, 32'd0);
        ex(K_RD, 32'd0, 0, 0, 1); ex(K_RSP, 0, 32'hFFFF_FF84, 0, 2);
        issue(1'b0, 3'b000, 32'd3, 32'd0);
        ex(K_RD, 32'd0, 0, 0, 1); ex(K_RSP, 0, 32'h0000_0084, 0, 2);
        issue(1'b0, 3'b100, 32'd3, 32'd0);
        ex(K_RD, 32'd0, 0, 0, 1); ex(K_RSP, 0, 32'hFFFF_8433, 0, 2);
        issue(1'b0, 3'b001, 32'd2, 32'd0);
        ex(K_RD, 32'd0, 0, 0, 1); ex(K_RSP, 0, 32'h0000_8433, 0, 2);
        issue(1'b0, 3'b101, 32'd2, 32'd0);

        // Sub-word store with read-modify-write.
        mem_w[1] = 32'd0;
        ex(K_RD, 32'd4, 0, 0, 1); ex(K_WR, 32'd4, 32'h0000_AB00, 0, 2); ex(K_RSP, 0, 0, 0, 3);
        issue(1'b1, 3'b000, 32'd5, 32'h0000_00AB);

        // Aligned SW skips the read, then read it back.
        ex(K_WR, 32'd8, 32'hDEAD_BEEF, 0, 1); ex(K_RSP, 0, 0, 0, 2);
        issue(1'b1, 3'b010, 32'd8, 32'hDEAD_BEEF);
        ex(K_RD, 32'd8, 0, 0, 1); ex(K_RSP, 0, 32'hDEAD_BEEF, 0, 2);
        issue(1'b0, 3'b010, 32'd8, 32'd0);

        // Crossing load and crossing store.
        mem_w[1] = 32'h7766_5544;
        ex(K_RD, 32'd0, 0, 0, 1); ex(K_RD, 32'd4, 0, 0, 2); ex(K_RSP, 0, 32'h5544_8433, 0, 3);
        issue(1'b0, 3'b010, 32'd2, 32'd0);
        ex(K_RD, 32'd0, 0, 0, 1); ex(K_WR, 32'd0, 32'hEF33_2211, 0, 2);
        ex(K_RD, 32'd4, 0, 0, 3); ex(K_WR, 32'd4, 32'h7766_55BE, 0, 4); ex(K_RSP, 0, 0, 0, 5);
        issue(1'b1, 3'b001, 32'd3, 32'h0000_BEEF);

        // Top-of-memory boundary: last byte legal, word straddling the end is not.
        mem_w[29] = 32'h7F00_0000;
        ex(K_RD, 32'd116, 0, 0, 1); ex(K_RSP, 0, 32'h0000_007F, 0, 2);
        issue(1'b0, 3'b000, 32'd119, 32'd0);
        ex(K_RSP, 0, 0, 1, 1);
        issue(1'b0, 3'b010, 32'd118, 32'd0);
        ex(K_RSP, 0, 0, 1, 1);
        issue(1'b0, 3'b011, 32'd0, 32'd0);
        ex(K_RSP, 0, 0, 1, 1);
        issue(1'b1, 3'b100, 32'd4, 32'h0000_0055);

        // Reset during RD_HI of a crossing LW: no response may follow.
        ex(K_RD, 32'd0, 0, 0, 1); ex(K_RD, 32'd4, 0, 0, 2);
        drive(1'b0, 3'b010, 32'd2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check_idle_outputs("mid_reset");
        repeat (5) @(negedge clk);
        check("mid_reset_queue_drained", 32'(q.size()), 32'd0);
        ex(K_RD, 32'd0, 0, 0, 1); ex(K_RSP, 0, 32'hEF33_2211, 0, 2);
        issue(1'b0, 3'b010, 32'd0, 32'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage initiator that turns one pipeline load/store request into aligned word transactions on the data-memory port.
- Handles byte, halfword and word accesses, including zero/sign extension.
- Does read-modify-write for sub-word stores.
- Splits accesses that cross a word boundary into two word accesses.
- Sits between the MEM pipeline stage and the byte-addressed data memory. The memory reads combinationally and writes on the clock edge.

Parameters:
- MEM_BYTES, 120, data-memory size in bytes; any access touching byte >= MEM_BYTES is an error.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; synchronous, active-high (1 = reset)
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept; 1 only in IDLE
- req_write_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RV32I width/sign code
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data; low bytes used
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  32  load result; 0 for stores and errors
- rsp_err_o  out  1  illegal funct3 or out-of-range; valid with rsp_valid_o
- mem_addr_o  out  32  word-aligned address; bits [1:0] always 0
- mem_data_o  out  32  merged write word
- mem_write_o  out  1  write strobe; memory commits at this posedge
- mem_read_o  out  1  read enable
- mem_data_i  in  32  read word, valid the same cycle as mem_read_o

Behaviour:
- Reset (rst_n=1 at posedge):
  - state goes to IDLE and any in-flight operation is dropped without a response.
  - All outputs are 0 except req_ready_o=1.
  - A store already half-written (WR_LO done, WR_HI pending) stays half-written; this is documented and accepted.
- Handshake:
  - A request is accepted on a posedge with req_valid_i & req_ready_o. Request fields are registered at that edge.
  - rsp_valid_o fires exactly once per accepted request, in state DONE.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Size = 1/2/4 bytes.
- Error check at acceptance:
  - Condition: illegal funct3, or addr+size-1 >= MEM_BYTES (compute in 33 bits, no wrap).
  - Result: go to DONE, set rsp_err_o=1, rsp_rdata_o=0, no memory access.
- Addressing:
  - base = addr & ~3, off = addr[1:0].
  - The access crosses a word boundary iff off+size > 4; the high word is base+4.
- Byte mapping: little-endian. Access byte k goes to memory byte addr+k, i.e. word lane (off+k) mod 4.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. mem_read_o and mem_write_o are never both 1.
- Load path: IDLE → RD_LO (read base, capture) → [RD_HI (read base+4, capture) if crossing] → DONE.
  - rsp_rdata_o is assembled from the captured bytes.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Store path: IDLE → RD_LO → WR_LO → [RD_HI → WR_HI if crossing] → DONE.
  - Each WR state drives the captured word with only the covered lanes replaced from wdata.
  - Exception: aligned SW skips RD_LO and goes IDLE → WR_LO, writing wdata directly.
- Latency from the accept edge to the rsp_valid_o cycle, in cycles:
  - error: 1
  - aligned LW/SW: 2
  - non-crossing sub-word load: 2
  - non-crossing sub-word store: 3
  - crossing load: 3
  - crossing store: 5
- DONE always returns to IDLE after 1 cycle. No back-to-back acceptance in DONE.
- mem_addr_o, mem_data_o = 0 when no strobe is active.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state_t enum
  - size-decode function
- Sub-module lsu_lane_align, purely combinational:
  - given off, size, funct3, the two captured words and wdata, it produces the merged write words and the extended load result.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Aligned loads: preload bytes 0..3 = 11,22,33,84.
  - LW @0 → rsp at cycle 2, rdata 0x84332211, one read at mem_addr 0.
  - LB @3 → 0xFFFFFF84.
  - LBU @3 → 0x00000084.
- Sub-word store: word @4 = 0; SB @5 wdata 0x000000AB.
  - Read @4, then write @4 data 0x0000AB00.
  - rsp at cycle 3, err 0, rdata 0.
- Crossing load: word0 = 0x84332211, word4 = 0x77665544; LW @2.
  - Reads @0 then @4.
  - rsp at cycle 3, rdata 0x55448433.
- Crossing store: same preload; SH @3 wdata 0xBEEF.
  - Sequence: read@0, write@0 0xEF332211, read@4, write@4 0x776655BE.
  - rsp at cycle 5.
- Errors: each must give rsp at cycle 1, err 1, and no mem strobe.
  - LW @118 with MEM_BYTES=120.
  - funct3=011 load.
  - SB funct3=100.
- Reset mid-operation: assert rst_n=1 during RD_HI of a crossing LW.
  - Next cycle: req_ready_o=1, all other outputs 0.
  - No rsp_valid_o ever for that request.
  - A new LW @0 then completes normally.
